// File: rtl/word_hash_framer.sv
// Running-hash byte framer: on each rising EndC, emits {SYNC, id, hash bytes MSB first} over valid/ready.
// Optional trailing XOR checksum byte is enabled by defining CHECKSUM_EN.
module word_hash_framer #(
   parameter int unsigned HASH_W    = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] X,
   input  logic       EndC,
   input  logic [2:0] Wfound,
   input  logic       TxReady,
   output logic [7:0] TxData,
   output logic       TxValid,
   output logic       Busy,
   output logic       Overflow,
   output logic [7:0] DropCount
);

   localparam int unsigned HB    = HASH_W / 8;
   localparam int unsigned IDX_W = (HB > 1) ? $clog2(HB) : 1;

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_HASH, S_CSUM} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ID, S_HASH} state_t;
`endif

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [2:0]          tx_id_q, tx_id_d;
   logic [HASH_W-1:0]   tx_hash_q, tx_hash_d;
   logic                pend_full_q, pend_full_d;
   logic [2:0]          pend_id_q, pend_id_d;
   logic [HASH_W-1:0]   pend_hash_q, pend_hash_d;
   logic [HASH_W-1:0]   hash_q, hash_d;
   logic                endc_q;
   logic                ovf_q, ovf_d;
   logic [7:0]          drop_q, drop_d;

   logic                capture;
   logic                xfer;
   logic                last;
   logic [7:0]          hash_byte;

   // h*31 + x, truncated to HASH_W bits
   function automatic logic [HASH_W-1:0] hash_step(input logic [HASH_W-1:0] h,
                                                   input logic [7:0] x);
      return (h << 5) - h + HASH_W'(x);
   endfunction

`ifdef CHECKSUM_EN
   function automatic logic [7:0] csum_of(input logic [2:0] id, input logic [HASH_W-1:0] h);
      logic [7:0] c;
      c = {5'b0, id};
      for (int i = 0; i < HB; i++) c = c ^ h[i*8 +: 8];
      return c;
   endfunction
`endif

   assign capture = EndC & ~endc_q;
   assign TxValid = (state_q != S_IDLE);
   assign xfer    = TxValid & TxReady;
   assign Busy    = TxValid | pend_full_q;
   assign Overflow  = ovf_q;
   assign DropCount = drop_q;

   always_comb begin
      hash_byte = 8'h00;
      for (int i = 0; i < HB; i++) begin
         if (idx_q == IDX_W'(i)) hash_byte = tx_hash_q[i*8 +: 8];
      end
   end

   always_comb begin
      TxData = 8'h00;
      case (state_q)
         S_SYNC:  TxData = SYNC_BYTE;
         S_ID:    TxData = {5'b0, tx_id_q};
         S_HASH:  TxData = hash_byte;
`ifdef CHECKSUM_EN
         S_CSUM:  TxData = csum_of(tx_id_q, tx_hash_q);
`endif
         default: TxData = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tx_id_d     = tx_id_q;
      tx_hash_d   = tx_hash_q;
      pend_full_d = pend_full_q;
      pend_id_d   = pend_id_q;
      pend_hash_d = pend_hash_q;
      ovf_d       = ovf_q;
      drop_d      = drop_q;
      last        = 1'b0;
      hash_d      = capture ? HASH_W'(X) : hash_step(hash_q, X);

      case (state_q)
         S_IDLE: begin
            if (capture) begin
               tx_id_d   = Wfound;
               tx_hash_d = hash_q;
               state_d   = S_SYNC;
            end
         end
         S_SYNC: if (xfer) state_d = S_ID;
         S_ID: begin
            if (xfer) begin
               state_d = S_HASH;
               idx_d   = IDX_W'(HB - 1);
            end
         end
         S_HASH: begin
            if (xfer) begin
               if (idx_q == '0) begin
`ifdef CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  last = 1'b1;
`endif
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
         end
`ifdef CHECKSUM_EN
         S_CSUM: if (xfer) last = 1'b1;
`endif
         default: state_d = S_IDLE;
      endcase

      // Frame end: promote pending (or a coincident capture) so the link never bubbles
      if (last) begin
         if (pend_full_q) begin
            tx_id_d   = pend_id_q;
            tx_hash_d = pend_hash_q;
            state_d   = S_SYNC;
            if (capture) begin
               pend_id_d   = Wfound;
               pend_hash_d = hash_q;
            end else begin
               pend_full_d = 1'b0;
            end
         end else if (capture) begin
            tx_id_d   = Wfound;
            tx_hash_d = hash_q;
            state_d   = S_SYNC;
         end else begin
            state_d = S_IDLE;
         end
      end else if ((state_q != S_IDLE) && capture) begin
         if (!pend_full_q) begin
            pend_full_d = 1'b1;
            pend_id_d   = Wfound;
            pend_hash_d = hash_q;
         end else begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         tx_id_q     <= '0;
         tx_hash_q   <= '0;
         pend_full_q <= 1'b0;
         pend_id_q   <= '0;
         pend_hash_q <= '0;
         hash_q      <= '0;
         endc_q      <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tx_id_q     <= tx_id_d;
         tx_hash_q   <= tx_hash_d;
         pend_full_q <= pend_full_d;
         pend_id_q   <= pend_id_d;
         pend_hash_q <= pend_hash_d;
         hash_q      <= hash_d;
         endc_q      <= EndC;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
      end
   end

endmodule

// File: tb/tb_word_hash_framer.sv
// Scoreboard bench for word_hash_framer (HASH_W=16); honours CHECKSUM_EN for frame length.
module tb_word_hash_framer;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] X;
   logic       EndC;
   logic [2:0] Wfound;
   logic       TxReady;
   logic [7:0] TxData;
   logic       TxValid;
   logic       Busy;
   logic       Overflow;
   logic [7:0] DropCount;

`ifdef CHECKSUM_EN
   localparam int FLEN = 5;
   localparam logic [15:0] B2B_HASH = 16'hA487;
`else
   localparam int FLEN = 4;
   localparam logic [15:0] B2B_HASH = 16'h2E99;
`endif

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   word_hash_framer #(.HASH_W(16), .SYNC_BYTE(8'hA5)) dut (
      .Clock(Clock), .Reset(Reset), .X(X), .EndC(EndC), .Wfound(Wfound),
      .TxReady(TxReady), .TxData(TxData), .TxValid(TxValid), .Busy(Busy),
      .Overflow(Overflow), .DropCount(DropCount)
   );

   always #5 Clock = ~Clock;

   // Monitor: every owed byte must be presented continuously and match the queue head
   always @(negedge Clock) begin
      if (!Reset) begin
         if (exp_q.size() != 0) begin
            checks++;
            if (!TxValid) begin
               failures++;
               $display("FAIL tx_gap: TxValid=%0b required 1 (%0d bytes owed)", TxValid, exp_q.size());
            end
         end
         if (TxValid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte: TxData=%02h required no byte", TxData);
            end else begin
               if (TxData !== exp_q[0]) begin
                  failures++;
                  $display("FAIL tx_byte: TxData=%02h required %02h", TxData, exp_q[0]);
               end
               if (TxReady) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [2:0] id, input logic [15:0] h);
      exp_q.push_back(8'hA5);
      exp_q.push_back({5'b0, id});
      exp_q.push_back(h[15:8]);
      exp_q.push_back(h[7:0]);
`ifdef CHECKSUM_EN
      exp_q.push_back({5'b0, id} ^ h[15:8] ^ h[7:0]);
`endif
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || TxValid) && n < 200) begin
         tick();
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", TxValid, 0);
   endtask

   task automatic do_reset();
      X = 8'h00; EndC = 1'b0; Wfound = 3'b000;
      Reset = 1'b1;
      exp_q.delete();
      tick(); tick();
      Reset = 1'b0;
      tick();
   endtask

   initial begin
      Reset = 1'b1; X = 8'h00; EndC = 1'b0; Wfound = 3'b000; TxReady = 1'b1;
      tick(); tick();
      check("rst_txdata", TxData, 8'h00);
      check("rst_txvalid", TxValid, 0);
      check("rst_busy", Busy, 0);
      check("rst_overflow", Overflow, 0);
      check("rst_dropcount", DropCount, 8'h00);
      Reset = 1'b0;
      tick();

      // Basic frame: hash of "ab" = 0x0C21
      X = 8'h61; tick();
      X = 8'h62; tick();
      X = 8'h00; EndC = 1'b1; Wfound = 3'b100; tick();
      push_frame(3'b100, 16'h0C21);
      EndC = 1'b0;
      drain();
      check("basic_busy", Busy, 0);
      check("basic_drop", DropCount, 8'h00);

      // Held EndC captures once
      do_reset();
      EndC = 1'b1; Wfound = 3'b010; tick();
      push_frame(3'b010, 16'h0000);
      repeat (4) tick();
      EndC = 1'b0;
      drain();
      check("hold_drop", DropCount, 8'h00);
      check("hold_ovf", Overflow, 0);

      // Stall mid-frame for 10 cycles
      do_reset();
      X = 8'h41; tick();
      X = 8'h00; EndC = 1'b1; Wfound = 3'b001; tick();
      push_frame(3'b001, 16'h0041);
      EndC = 1'b0;
      tick();
      TxReady = 1'b0;
      repeat (10) tick();
      check("stall_valid", TxValid, 1);
      check("stall_data", TxData, 8'h01);
      TxReady = 1'b1;
      drain();

      // Three captures under backpressure: third dropped
      do_reset();
      TxReady = 1'b0;
      EndC = 1'b1; Wfound = 3'b001; X = 8'h63; tick();
      push_frame(3'b001, 16'h0000);
      EndC = 1'b0; X = 8'h00; tick(); tick();
      EndC = 1'b1; Wfound = 3'b010; tick();
      push_frame(3'b010, 16'h73A3);
      EndC = 1'b0; tick(); tick();
      EndC = 1'b1; Wfound = 3'b100; tick();
      EndC = 1'b0; tick();
      check("ovf_flag", Overflow, 1);
      check("ovf_count", DropCount, 8'h01);
      check("ovf_busy", Busy, 1);
      TxReady = 1'b1;
      drain();
      check("ovf_count_after", DropCount, 8'h01);
      check("ovf_busy_after", Busy, 0);

      // Capture coincident with last-byte transfer, pending empty
      do_reset();
      EndC = 1'b1; Wfound = 3'b001; X = 8'h07; tick();
      push_frame(3'b001, 16'h0000);
      EndC = 1'b0; X = 8'h00;
      repeat (FLEN - 1) tick();
      EndC = 1'b1; Wfound = 3'b110; tick();
      push_frame(3'b110, B2B_HASH);
      EndC = 1'b0;
      check("b2b_valid", TxValid, 1);
      check("b2b_sync", TxData, 8'hA5);
      drain();

      // Asynchronous reset during byte 2 aborts the frame
      do_reset();
      EndC = 1'b1; Wfound = 3'b011; tick();
      push_frame(3'b011, 16'h0000);
      EndC = 1'b0;
      tick(); tick();
      #2;
      Reset = 1'b1;
      exp_q.delete();
      #1;
      check("rstmid_valid", TxValid, 0);
      check("rstmid_busy", Busy, 0);
      check("rstmid_data", TxData, 8'h00);
      tick();
      Reset = 1'b0;
      tick();
      X = 8'h61; tick();
      X = 8'h00; EndC = 1'b1; Wfound = 3'b001; tick();
      push_frame(3'b001, 16'h0061);
      EndC = 1'b0;
      drain();
      check("rstmid_ovf", Overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
